// File: rtl/uart_rx_pkg.sv
// Purpose: shared types and constants for the UART receive controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

    localparam int DATA_WIDTH = 8;

    // Oversampling ratios the bit timing supports
    localparam int unsigned PS_8  = 8;
    localparam int unsigned PS_16 = 16;
    localparam int unsigned PS_32 = 32;

    // Bit index of the start bit; the stop bit follows the data bits
    // (one position later again when a parity bit is present)
    localparam logic [3:0] START_BIT = 4'd0;
    localparam logic [3:0] STOP_BIT  = 4'(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic logic ps_legal(input int unsigned ps);
        return (ps == PS_8) || (ps == PS_16) || (ps == PS_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Purpose: oversampling edge counter and frame bit counter.
// Latency: counts update one cycle after enable; clear takes effect next edge.
// Backpressure: none, free-running while enabled.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [3:0]            r_bit_cnt;
    logic                  w_wrap;

    assign w_wrap   = (r_edge_cnt == prescale - PRESCALE_W'(1));
    assign edge_cnt = r_edge_cnt;
    assign bit_cnt  = r_bit_cnt;

    // Edge counter wraps at prescale-1 and advances the bit index on the wrap
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (enable) begin
            if (w_wrap) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Purpose: UART receive frame FSM and datapath enable decode.
// Latency: data_valid one cycle after the stop bit ends (frame cycle N*prescale).
// Backpressure: none; the serial line cannot be stalled, frames may run back to back.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  cfg_err
);

    state_e                r_state;
    state_e                w_next_state;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en;
    logic                  r_par_flag;
    logic                  r_stp_flag;
    logic                  r_data_valid;
    logic                  r_cfg_err;

    logic [PRESCALE_W-1:0] w_edge_cnt;
    logic [3:0]            w_bit_cnt;
    logic [PRESCALE_W-1:0] w_ps_cnt;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_samp_lo;
    logic [PRESCALE_W-1:0] w_samp_hi;
    logic [PRESCALE_W-1:0] w_chk_pt;
    logic                  w_idle;
    logic                  w_ps_ok;
    logic                  w_start;
    logic                  w_bit_end;
    logic                  w_chk;
    logic                  w_cnt_en;
    logic                  w_cnt_clr;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_ps_ok = ps_legal(32'(prescale));
    // The cycle in which the falling edge is seen counts as edge 0 of the
    // start bit, so back-to-back frames repeat with no gap cycle.
    assign w_start = w_idle && !RX_IN && w_ps_ok;

    // Before the latch is loaded (detection cycle) the live prescale drives the counter
    assign w_ps_cnt  = w_idle ? prescale : r_prescale;
    assign w_half    = r_prescale >> 1;
    assign w_samp_lo = w_half - PRESCALE_W'(1);
    assign w_samp_hi = w_half + PRESCALE_W'(1);
    assign w_chk_pt  = w_half + PRESCALE_W'(2);

    assign w_bit_end = !w_idle && (w_edge_cnt == r_prescale - PRESCALE_W'(1));
    assign w_chk     = !w_idle && (w_edge_cnt == w_chk_pt);

    // Counters run through the frame and are zeroed whenever the FSM lands in IDLE
    assign w_cnt_en  = !w_idle || w_start;
    assign w_cnt_clr = (w_next_state == ST_IDLE);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .enable   (w_cnt_en),
        .clear    (w_cnt_clr),
        .prescale (w_ps_cnt),
        .edge_cnt (w_edge_cnt),
        .bit_cnt  (w_bit_cnt)
    );

    assign edge_cnt   = w_edge_cnt;
    assign bit_cnt    = w_bit_cnt;
    assign data_valid = r_data_valid;
    // Raised after a full idle cycle with a bad ratio, dropped as soon as a legal one appears
    assign cfg_err    = r_cfg_err && w_idle && !w_ps_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: every bit ends on the edge-counter wrap
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (w_chk && strt_glitch) begin
                    w_next_state = ST_IDLE;
                end else if (w_bit_end && (w_bit_cnt == START_BIT)) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (w_bit_cnt == 4'(DATA_WIDTH))) begin
                    w_next_state = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: majority-vote sample window and one-cycle check pulses
    always_comb begin
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        if (!w_idle) begin
            dat_samp_en = (w_edge_cnt >= w_samp_lo) && (w_edge_cnt <= w_samp_hi);
        end
        case (r_state)
            ST_START:  strt_chk_en = w_chk;
            ST_DATA:   deser_en    = w_chk;
            ST_PARITY: par_chk_en  = w_chk;
            ST_STOP:   stp_chk_en  = w_chk;
            default:   ;
        endcase
    end

    // Frame configuration latch, error flags and the registered valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale   <= '0;
            r_par_en     <= 1'b0;
            r_par_flag   <= 1'b0;
            r_stp_flag   <= 1'b0;
            r_data_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            if (w_start) begin
                r_prescale <= prescale;
                r_par_en   <= PAR_EN;
                r_par_flag <= 1'b0;
                r_stp_flag <= 1'b0;
            end else begin
                if (par_chk_en && par_err) begin
                    r_par_flag <= 1'b1;
                end
                if (stp_chk_en) begin
                    r_stp_flag <= stp_err;
                end
            end
            r_data_valid <= (r_state == ST_STOP) && w_bit_end && !r_par_flag && !r_stp_flag;
            r_cfg_err    <= w_idle && !w_ps_ok;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] prescale;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          cfg_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit exp_dv = 1'b0;
    int dv_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (data_valid === 1'b1) dv_q.push_back(cyc);

    uart_rx_ctrl #(
        .DATA_WIDTH (8),
        .PRESCALE_W (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .prescale    (prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .cfg_err     (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // {cfg_err, edge_cnt, bit_cnt, samp, deser, strt, par, stp, valid}
    function automatic logic [31:0] obs_word();
        return {15'd0, cfg_err, edge_cnt, bit_cnt, dat_samp_en, deser_en,
                strt_chk_en, par_chk_en, stp_chk_en, data_valid};
    endfunction

    // Expected outputs at cycle k of a frame, from the bit-timing arithmetic
    function automatic logic [31:0] model_word(input int p, input bit pen, input int k);
        int   e, b, h, nb;
        logic cp, samp;
        e    = k % p;
        b    = k / p;
        h    = p / 2;
        nb   = pen ? 11 : 10;
        cp   = (e == h + 2);
        samp = (e >= h - 1) && (e <= h + 1);
        return {15'd0, 1'b0, 6'(e), 4'(b), samp,
                cp && (b >= 1) && (b <= 8),
                cp && (b == 0),
                cp && pen && (b == 9),
                cp && (b == nb - 1),
                1'b0};
    endfunction

    function automatic logic line_bit(input logic [7:0] d, input bit pen, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen && b == 9) return ~^d;
        return 1'b1;
    endfunction

    function automatic int ps_pick(input int unsigned r);
        if (r == 0) return 8;
        if (r == 1) return 16;
        return 32;
    endfunction

    // One frame starting in the current idle cycle; g stops it at the start
    // check point, rst_at >= 0 asserts reset in that frame cycle and stops.
    task automatic run_frame(input int p, input bit pen, input logic [7:0] d,
                             input bit g, input bit pe, input bit se, input int rst_at);
        int last, nb, h, e, b;
        nb   = pen ? 11 : 10;
        h    = p / 2;
        last = g ? h + 2 : ((rst_at >= 0) ? rst_at : nb * p - 1);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            e     = k % p;
            b     = k / p;
            rst   = (k == rst_at);
            RX_IN = line_bit(d, pen, b);
            if (k == 0) begin
                PAR_EN   = pen;
                prescale = PW'(p);
            end else begin
                PAR_EN   = 1'($urandom);
                prescale = PW'($urandom);
            end
            strt_glitch = (e == h + 2 && b == 0) ? g : 1'($urandom);
            par_err     = (e == h + 2 && pen && b == 9) ? pe : 1'($urandom);
            stp_err     = (e == h + 2 && b == nb - 1) ? se : 1'($urandom);
            #1;
            chk("frame", obs_word(), model_word(p, pen, k) | ((k == 0 && exp_dv) ? 32'd1 : 32'd0));
            if (k == 0) exp_dv = 1'b0;
        end
        exp_dv = !g && (rst_at < 0) && !(pen && pe) && !se;
    endtask

    task automatic idle(input int n, input int p);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst         = 1'b0;
            RX_IN       = 1'b1;
            prescale    = PW'(p);
            PAR_EN      = 1'($urandom);
            strt_glitch = 1'($urandom);
            par_err     = 1'($urandom);
            stp_err     = 1'($urandom);
            #1;
            chk("idle", obs_word(), exp_dv ? 32'd1 : 32'd0);
            exp_dv = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[7];
        int p;
        bit pen;

        rst = 1'b1; RX_IN = 1'b0; PAR_EN = 1'b0; prescale = PW'(8);
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset", obs_word(), 32'd0);
        idle(3, 8);

        // A: prescale 8 with parity
        run_frame(8, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, -1);
        idle(2, 8);
        // B: prescale 16 without parity
        run_frame(16, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, -1);
        idle(2, 16);
        // C: start glitch aborts the frame
        run_frame(8, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, -1);
        idle(6, 8);
        // D: parity error then stop error, back to back
        run_frame(8, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, -1);
        run_frame(16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, -1);
        idle(2, 16);

        // E: seven back-to-back frames
        dv_q.delete();
        for (int i = 0; i < 7; i++) begin
            p       = ps_pick($urandom % 3);
            pen     = 1'($urandom);
            lens[i] = (pen ? 11 : 10) * p;
            run_frame(p, pen, 8'($urandom), 1'b0, 1'b0, 1'b0, -1);
        end
        idle(2, 8);
        chk("e_count", dv_q.size(), 7);
        if (dv_q.size() == 7) begin
            for (int i = 1; i < 7; i++) chk("e_gap", dv_q[i] - dv_q[i-1], lens[i]);
        end

        // F: illegal prescale blocks start detection
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            prescale = PW'(12);
            RX_IN    = (i == 0);
            #1;
            chk("cfg_nostart", obs_word() & 32'h0FFFF, 32'd0);
            if (i >= 2) chk("cfg_err", cfg_err, 1);
        end
        @(negedge clk);
        prescale = PW'(8);
        RX_IN    = 1'b1;
        #1;
        chk("cfg_clr", cfg_err, 0);
        // F: reset mid-frame, then a frame starting in the first cycle after reset
        run_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 40);
        run_frame(8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
        idle(2, 8);

        // Randomized frames with random errors, glitches and gaps
        for (int i = 0; i < 8; i++) begin
            int gap;
            p   = ps_pick($urandom % 3);
            gap = $urandom % 3;
            run_frame(p, 1'($urandom), 8'($urandom), ($urandom % 6) == 0,
                      ($urandom % 4) == 0, ($urandom % 4) == 0, -1);
            if (gap > 0) idle(gap, p);
        end
        idle(2, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
